// File: rtl/l2_instr_bus_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_instr_bus_ctrl_pkg : shared types/constants for the L2 instr bus   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package l2_instr_bus_ctrl_pkg;

  localparam int          L2_NUM_CACHES   = 4;
  localparam logic [31:0] L2_PATTERN_BASE = 32'hA000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GNT  = 3'd1,
    ST_ADDR = 3'd2,
    ST_LAT  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Word index of a cache line address: drop the byte offset, keep the low aw bits.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int aw);
    return (addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_instr_bus_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_instr_bus_ctrl_if : request/grant/address/strobe bundle            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface l2_instr_bus_ctrl_if #(
  parameter int NUM_CACHES = 4
);
  logic [NUM_CACHES-1:0] Com_Bus_Req_proc;
  logic [NUM_CACHES-1:0] Com_Bus_Gnt_proc;
  logic [31:0]           Address_Com;
  logic                  Data_in_Bus;

  modport master (
    output Com_Bus_Req_proc,
    output Address_Com,
    input  Com_Bus_Gnt_proc,
    input  Data_in_Bus
  );

  modport slave (
    input  Com_Bus_Req_proc,
    input  Address_Com,
    output Com_Bus_Gnt_proc,
    output Data_in_Bus
  );
endinterface
`default_nettype wire

// File: rtl/l2_instr_bus_ctrl_rr_arbiter4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter4 : combinational 4-way round-robin pick starting at ptr    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_arbiter4
  import l2_instr_bus_ctrl_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt_onehot,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit then wins.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[3:0];

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign any        = |req;
  assign gnt_id     = ptr + off;
  assign gnt_onehot = any ? (4'b0001 << gnt_id) : 4'b0000;

endmodule
`default_nettype wire

// File: rtl/l2_instr_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_instr_bus_ctrl : round-robin bus arbiter + stub L2 instr memory    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module l2_instr_bus_ctrl
  import l2_instr_bus_ctrl_pkg::*;
#(
  parameter int    NUM_CACHES = L2_NUM_CACHES,
  parameter int    L2_LATENCY = 3,
  parameter int    MEM_ADDR_W = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic               clk,
  input  logic               rst,
  l2_instr_bus_ctrl_if.slave bus,
  output tri   [31:0]        Data_Bus_Com
);

  localparam int                DEPTH    = 1 << MEM_ADDR_W;
  localparam int                LAT_W    = $clog2(L2_LATENCY + 2);
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(L2_LATENCY);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

  state_t                state;
  logic [NUM_CACHES-1:0] gnt_q;
  logic [1:0]            winner;
  logic [1:0]            rr_ptr;
  logic [LAT_W-1:0]      lat_cnt;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  resp_valid;
  logic [31:0]           resp_data;

  logic [3:0]            arb_gnt;
  logic [1:0]            arb_id;
  logic                  arb_any;
  logic                  win_req;
  logic [MEM_ADDR_W-1:0] addr_idx;
  logic [MEM_ADDR_W-1:0] rd_idx;
  logic [31:0]           rom_word;

  rr_arbiter4 u_arb (
    .req        (bus.Com_Bus_Req_proc),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_gnt),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  assign win_req  = bus.Com_Bus_Req_proc[winner];
  assign addr_idx = MEM_ADDR_W'(word_index(bus.Address_Com, MEM_ADDR_W));
  // With zero latency the read happens on the capture edge, so bypass addr_q.
  assign rd_idx   = (state == ST_ADDR) ? addr_idx : addr_q;

  assign rom_word = L2_PATTERN_BASE + 32'(rd_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt_q      <= '0;
      winner     <= 2'd0;
      rr_ptr     <= 2'd0;
      lat_cnt    <= '0;
      addr_q     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (state != ST_IDLE && !win_req) begin
      // Winner dropped its request: finish or abandon, either way release everything.
      state      <= ST_IDLE;
      gnt_q      <= '0;
      lat_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      rr_ptr     <= winner + 2'd1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q  <= arb_gnt;
            winner <= arb_id;
            state  <= ST_GNT;
          end
        end
        ST_GNT: begin
          state <= ST_ADDR;
        end
        ST_ADDR: begin
          addr_q <= addr_idx;
          if (L2_LATENCY == 0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_data  <= rom_word;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= ST_LAT;
          end
        end
        ST_LAT: begin
          lat_cnt <= lat_cnt - LAT_ONE;
          if (lat_cnt == LAT_ONE) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_data  <= rom_word;
          end
        end
        ST_RESP: begin
          state <= ST_RESP;
        end
        default: begin
          state <= ST_IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.Com_Bus_Gnt_proc = gnt_q;
  assign bus.Data_in_Bus      = resp_valid;
  assign Data_Bus_Com         = resp_valid ? resp_data : 32'hzzzz_zzzz;

  a_addr_known: assert property (@(posedge clk) disable iff (rst)
    (state == ST_ADDR && win_req) |-> !$isunknown(bus.Address_Com));

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q));

endmodule
`default_nettype wire

// File: tb/tb_l2_instr_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_l2_instr_bus_ctrl : directed + random bench, latency 3 and 0 DUTs  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_l2_instr_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] addr;
  wire  [31:0] data3;
  wire  [31:0] data0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l2_instr_bus_ctrl_if #(.NUM_CACHES(4)) bus3 ();
  l2_instr_bus_ctrl_if #(.NUM_CACHES(4)) bus0 ();

  assign bus3.Com_Bus_Req_proc = req;
  assign bus3.Address_Com      = addr;
  assign bus0.Com_Bus_Req_proc = req;
  assign bus0.Address_Com      = addr;

  l2_instr_bus_ctrl #(.NUM_CACHES(4), .L2_LATENCY(3), .MEM_ADDR_W(10), .INIT_FILE("")) dut3 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus3),
    .Data_Bus_Com (data3)
  );

  l2_instr_bus_ctrl #(.NUM_CACHES(4), .L2_LATENCY(0), .MEM_ADDR_W(10), .INIT_FILE("")) dut0 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus0),
    .Data_Bus_Com (data0)
  );

  // Reference: index 0 is the latency-3 DUT, index 1 the latency-0 DUT.
  // A transaction is described by its winner and its age in cycles since the grant edge.
  int m_busy [2];
  int m_win  [2];
  int m_age  [2];
  int m_idx  [2];
  int m_ptr  [2];
  int lat_of [2] = '{3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs_gnt(input int d);
    return (d == 0) ? bus3.Com_Bus_Gnt_proc : bus0.Com_Bus_Gnt_proc;
  endfunction

  function automatic logic obs_dv(input int d);
    return (d == 0) ? bus3.Data_in_Bus : bus0.Data_in_Bus;
  endfunction

  function automatic logic [31:0] obs_data(input int d);
    return (d == 0) ? data3 : data0;
  endfunction

  function automatic int onehot_id(input logic [3:0] g);
    int id;
    id = -1;
    for (int k = 0; k < 4; k++) if (g[k]) id = k;
    return id;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_win[d] = 0; m_age[d] = 0; m_idx[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    if (m_busy[d] != 0) begin
      if (req[m_win[d]] == 1'b0) begin
        m_busy[d] = 0;
        m_ptr[d]  = (m_win[d] + 1) % 4;
      end else begin
        if (m_age[d] == 1) m_idx[d] = int'((addr >> 2) % 1024);
        if (m_age[d] < 1000) m_age[d]++;
      end
    end else if (req != 4'b0000) begin
      for (int k = 3; k >= 0; k--)
        if (req[(m_ptr[d] + k) % 4]) m_win[d] = (m_ptr[d] + k) % 4;
      m_busy[d] = 1;
      m_age[d]  = 0;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    logic       ev;
    for (int d = 0; d < 2; d++) begin
      eg = (m_busy[d] != 0) ? 4'(1 << m_win[d]) : 4'b0000;
      ev = (m_busy[d] != 0) && (m_age[d] >= 2 + lat_of[d]);
      chk($sformatf("gnt[dut%0d]", d), 32'(obs_gnt(d)), 32'(eg));
      chk($sformatf("data_in_bus[dut%0d]", d), 32'(obs_dv(d)), 32'(ev));
      if (ev) chk($sformatf("data_bus[dut%0d]", d), obs_data(d), 32'hA000_0000 + 32'(m_idx[d]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         exp_ord [5] = '{0, 1, 2, 3, 0};
    int         order   [$];
    logic [3:0] prev;

    rst  = 1'b1;
    req  = 4'b0000;
    addr = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_gnt3", 32'(bus3.Com_Bus_Gnt_proc), 32'h0);
    chk("reset_dv3",  32'(bus3.Data_in_Bus), 32'h0);
    chk("reset_gnt0", 32'(bus0.Com_Bus_Gnt_proc), 32'h0);
    chk("reset_dv0",  32'(bus0.Data_in_Bus), 32'h0);
    rst = 1'b0;

    // Single request from cache 2, address 0x10
    req = 4'b0100;
    cycle();
    chk("single_gnt", 32'(bus3.Com_Bus_Gnt_proc), 32'h4);
    cycle();
    addr = 32'h0000_0010;
    repeat (4) cycle();
    chk("single_dv",   32'(bus3.Data_in_Bus), 32'h1);
    chk("single_data", data3, 32'hA000_0004);
    req = 4'b0000;
    cycle();
    chk("single_release_gnt", 32'(bus3.Com_Bus_Gnt_proc), 32'h0);
    chk("single_release_dv",  32'(bus3.Data_in_Bus), 32'h0);

    // Zero-latency response with an aliased address
    req  = 4'b0001;
    addr = 32'h0000_1004;
    repeat (3) cycle();
    chk("lat0_dv",   32'(bus0.Data_in_Bus), 32'h1);
    chk("lat0_wrap", data0, 32'hA000_0001);
    req = 4'b0000;
    cycle();

    // Abandon: cache 1 drops during LAT on the latency-3 DUT
    req  = 4'b0010;
    addr = $urandom;
    repeat (4) cycle();
    req = 4'b0101;
    cycle();
    chk("abandon_gnt", 32'(bus3.Com_Bus_Gnt_proc), 32'h0);
    chk("abandon_dv",  32'(bus3.Data_in_Bus), 32'h0);
    cycle();
    chk("abandon_next", 32'(bus3.Com_Bus_Gnt_proc), 32'h4);
    req = 4'b0000;
    repeat (2) cycle();

    // Asynchronous reset while responding
    do_reset();
    req  = 4'b0100;
    addr = 32'h0000_0088;
    repeat (6) cycle();
    chk("pre_rst_dv", 32'(bus3.Data_in_Bus), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt3", 32'(bus3.Com_Bus_Gnt_proc), 32'h0);
    chk("async_dv3",  32'(bus3.Data_in_Bus), 32'h0);
    chk("async_gnt0", 32'(bus0.Com_Bus_Gnt_proc), 32'h0);
    chk("async_dv0",  32'(bus0.Data_in_Bus), 32'h0);
    model_reset();
    req = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("post_rst_first", 32'(bus3.Com_Bus_Gnt_proc), 32'h2);

    // Round-robin with all four requesting, each dropping for one cycle after its fill
    do_reset();
    req  = 4'b1111;
    prev = 4'b0000;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      cycle();
      if (bus3.Com_Bus_Gnt_proc != 4'b0000 && prev == 4'b0000)
        order.push_back(onehot_id(bus3.Com_Bus_Gnt_proc));
      prev = bus3.Com_Bus_Gnt_proc;
      req  = 4'b1111;
      if (bus3.Data_in_Bus) req[onehot_id(bus3.Com_Bus_Gnt_proc)] = 1'b0;
    end
    chk("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_ord[i]));

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (req[k]) begin
          if ($urandom_range(5) == 0) req[k] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req[k] = 1'b1;
        end
      end
      addr = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/l2_instr_bus_ctrl.md
Name: l2_instr_bus_ctrl

Overview:
- Downstream stage of the four per-core instruction cache blocks on the shared instruction common bus.
- Arbitrates the caches' Com_Bus_Req_proc lines round-robin and returns a single Com_Bus_Gnt_proc.
- Acts as the stub L2 instruction memory: samples Address_Com from the granted cache, waits a fixed latency, then drives Data_Bus_Com with Data_in_Bus=1 so the cache can fill its miss block.
- Read-only; there is no write path.

Parameters:
- NUM_CACHES, 4, number of requesting caches; arbiter logic is written for 4.
- L2_LATENCY, 3, LAT-state cycles between address capture and the response (0 allowed).
- MEM_ADDR_W, 10, word-address width of the L2 array (depth 1<<MEM_ADDR_W).
- INIT_FILE, "", hex file for $readmemh; if empty, mem[i] = 32'hA000_0000 + i.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- Com_Bus_Req_proc  in  NUM_CACHES  per-cache bus request; bit k belongs to cache k
- Com_Bus_Gnt_proc  out  NUM_CACHES  one-hot grant, or all zero
- Address_Com  in  32  line address from the granted cache ({tag,index,2'b00})
- Data_Bus_Com  out(tri)  32  fill data; Z when not responding
- Data_in_Bus  out  1  fill-data-valid strobe; driven 0 when not responding, never Z

Behaviour:
- Reset (async, immediate):
  - state=IDLE; Com_Bus_Gnt_proc=0; Data_in_Bus=0; Data_Bus_Com=Z.
  - rr_ptr=0; lat_cnt=0; captured address cleared.
  - Asserting rst mid-transaction aborts it with no response. The memory array is not reset.
- All outputs are registered; state changes on posedge clk.
- FSM states: IDLE, GNT, ADDR, LAT, RESP.
- IDLE:
  - If any request bit is set, grant the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... mod 4).
  - Register the one-hot grant and the winner id; go to GNT.
- GNT: one cycle, grant held. This lets the cache see the grant and drive Address_Com. Go to ADDR.
- ADDR:
  - Capture Address_Com[MEM_ADDR_W+1:2] at the end of this cycle; bits [1:0] are ignored.
  - Higher address bits above MEM_ADDR_W+1 are ignored, so addresses alias (wrap) into the array.
  - Go to LAT with lat_cnt=L2_LATENCY, or directly to RESP if L2_LATENCY=0.
- LAT: decrement lat_cnt each cycle; go to RESP when it reaches 1→0.
- RESP:
  - Data_in_Bus=1 and Data_Bus_Com=mem[captured]; both held stable every cycle.
  - Stay until the winner's request bit is sampled low.
  - Then go to IDLE: grant, Data_in_Bus and Data_Bus_Com release on that same edge; rr_ptr=(winner+1) mod 4.
- Abandon: if the winner's request bit is sampled low in GNT, ADDR or LAT, go to IDLE with no response driven.
  - rr_ptr still advances to winner+1.
- Requests from non-winners are ignored while busy; they are re-arbitrated in IDLE. Max one outstanding transaction.
- Simultaneous requests: only one winner per IDLE cycle, chosen by rr_ptr order.
- No back-to-back grant: at least one IDLE cycle separates transactions.
- Grant is always one-hot or zero; it is nonzero only in GNT, ADDR, LAT and RESP.
- Address_Com containing X/Z when sampled is a protocol violation; assert it in simulation only.

Decomposition:
- Shared package/include: state encoding constants, NUM_CACHES, the L2 default-pattern base (32'hA000_0000), and the address-slice macros reused from the cache definitions.
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_onehot[3:0], gnt_id[1:0], any.
  - Purely combinational; the FSM registers its outputs.

Test Plan:
- Single request, L2_LATENCY=3: Com_Bus_Req_proc=4'b0100 before edge0; cache drives Address_Com=32'h0000_0010 after edge1 → Gnt=4'b0100 after edge0; Data_in_Bus=1 and Data_Bus_Com=32'hA000_0004 after edge5; after req drops, Gnt=0 and Data_Bus_Com=Z on the next edge.
- Round-robin fairness: all four requests held continuously, each dropping after its fill → grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Abandon: req[1] drops during LAT → no Data_in_Bus pulse, grant drops, rr_ptr=2 (next grant goes to cache 2 if it is requesting).
- Latency 0 and wrap: L2_LATENCY=0, Address_Com=32'h0000_1004 with MEM_ADDR_W=10 → RESP directly after ADDR, data=32'hA000_0001 (aliased index 1).
- Async reset in RESP: assert rst mid-cycle → Data_in_Bus=0, Data_Bus_Com=Z and Gnt=0 immediately, without waiting for an edge; after release, the first grant goes to the lowest-numbered requester.
